tx_ctrl: RTL and testbench

UART transmit control unit: the sequencing FSM for the transmit datapath, the counterpart of the receive control unit. It accepts a byte from the upstream producer with a valid/ready handshake. It then sequences the transmit shift register and the serial-line output mux through start, data and stop bit periods, owning all bit-period and bit-count timing. The shift register and output mux are separate datapath blocks driven by this unit.

---
 rtl/uart_pkg.sv | 42 ++++
 rtl/flex_counter.sv | 42 ++++
 rtl/tx_ctrl.sv | 136 +++++++++++++
 tb/tb_tx_ctrl.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART types and default frame constants.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  // Default frame timing
  localparam int DEF_CLKS_PER_BIT = 10;
  localparam int DEF_DATA_BITS    = 8;

  // Transmit controller states; encoding matches the output mux select
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  // Serial-line output mux select
  typedef enum logic [1:0] {
    SEL_IDLE  = 2'd0,   // line held high
    SEL_START = 2'd1,   // line driven low
    SEL_DATA  = 2'd2,   // line follows shifter LSB
    SEL_STOP  = 2'd3    // line held high
  } tx_sel_t;

  // Map a controller state onto the mux select it drives
  function automatic tx_sel_t state_to_sel(input tx_state_t st);
    tx_sel_t sel;
    case (st)
      START:   sel = SEL_START;
      DATA:    sel = SEL_DATA;
      STOP:    sel = SEL_STOP;
      default: sel = SEL_IDLE;
    endcase
    return sel;
  endfunction

endpackage
`default_nettype wire

// File: rtl/flex_counter.sv
`default_nettype none
// ============================================================================
// Module      : flex_counter
// Description : Up counter 0..rollover_val with synchronous clear, count
//               enable and a combinational terminal-count flag.
// Revision    : 1.0 - initial release
// ============================================================================
module flex_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clear,
  input  logic             count_enable,
  input  logic [WIDTH-1:0] rollover_val,
  output logic             rollover_flag
);

  logic [WIDTH-1:0] count;

  // Count register: clear has priority, wraps to zero at the terminal value
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (count_enable) begin
      if (count == rollover_val) begin
        count <= '0;
      end else begin
        count <= count + WIDTH'(1);
      end
    end
  end

  // Flag is asserted for the whole cycle in which the terminal value is held
  always_comb begin
    rollover_flag = (count == rollover_val);
  end

endmodule
`default_nettype wire

// File: rtl/tx_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tx_ctrl
// Description : UART transmit sequencing FSM. Accepts a byte via valid/ready,
//               then drives shifter load/shift strobes and the line mux
//               select through start, data and stop bit periods.
// Revision    : 1.0 - initial release
// ============================================================================
module tx_ctrl
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int DATA_BITS    = DEF_DATA_BITS
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       tx_valid,
  input  logic       tx_abort,
  output logic       tx_ready,
  output logic       load_shifter,
  output logic       shift_enable,
  output logic [1:0] tx_sel,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] PERIOD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST    = BW'(DATA_BITS - 1);

  tx_state_t     state;
  tx_state_t     next_state;
  logic          busy;
  logic          cnt_clear;
  logic          period_flag;
  logic          period_end;
  logic [BW-1:0] bit_cnt;
  logic          last_bit;

  // Frame-level status derived from the current state
  always_comb begin
    busy       = (state != IDLE);
    // Any state transition or abort restarts bit-period timing from zero
    cnt_clear  = (next_state != state) || (tx_abort && busy);
    period_end = period_flag && busy;
    last_bit   = (bit_cnt == BIT_LAST);
  end

  // Bit-period timer; its terminal flag marks the last cycle of each bit
  flex_counter #(
    .WIDTH (CW)
  ) u_period_cnt (
    .clk           (clk),
    .n_rst         (n_rst),
    .clear         (cnt_clear),
    .count_enable  (busy),
    .rollover_val  (PERIOD_LAST),
    .rollover_flag (period_flag)
  );

  // State register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Data-bit counter; the DATA->STOP transition clears it before it can wrap
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      bit_cnt <= '0;
    end else if (cnt_clear) begin
      bit_cnt <= '0;
    end else if ((state == DATA) && period_end) begin
      bit_cnt <= bit_cnt + BW'(1);
    end
  end

  // Next-state and strobe decode; abort overrides any coincident period end
  always_comb begin
    next_state   = state;
    tx_ready     = 1'b0;
    load_shifter = 1'b0;
    shift_enable = 1'b0;
    tx_done      = 1'b0;
    tx_busy      = busy;
    tx_sel       = state_to_sel(state);

    case (state)
      IDLE: begin
        tx_ready = ~tx_abort;
        if (tx_valid && !tx_abort) begin
          load_shifter = 1'b1;
          next_state   = START;
        end
      end

      START: begin
        if (tx_abort) begin
          next_state = IDLE;
        end else if (period_end) begin
          next_state = DATA;
        end
      end

      DATA: begin
        if (tx_abort) begin
          next_state = IDLE;
        end else if (period_end) begin
          shift_enable = 1'b1;
          if (last_bit) begin
            next_state = STOP;
          end
        end
      end

      STOP: begin
        if (tx_abort) begin
          next_state = IDLE;
        end else if (period_end) begin
          tx_done    = 1'b1;
          next_state = IDLE;
        end
      end

      default: begin
        next_state = IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_tx_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_tx_ctrl
// Description : Directed self-checking bench for tx_ctrl (default parameters).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tx_ctrl;

  localparam int C     = 10;
  localparam int N     = 8;
  localparam int FRAME = (N + 2) * C;   // cycle of tx_done, 100

  // {load_shifter, tx_sel[1:0], shift_enable, tx_done, tx_ready, tx_busy}
  localparam logic [6:0] IDLE_VEC  = 7'b0_00_0_0_1_0;
  localparam logic [6:0] BLOCK_VEC = 7'b0_00_0_0_0_0;

  logic       clk;
  logic       n_rst;
  logic       tx_valid;
  logic       tx_abort;
  logic       tx_ready;
  logic       load_shifter;
  logic       shift_enable;
  logic [1:0] tx_sel;
  logic       tx_busy;
  logic       tx_done;

  int num_checks = 0;
  int num_errors = 0;
  int done_seen  = 0;

  tx_ctrl #(
    .CLKS_PER_BIT (C),
    .DATA_BITS    (N)
  ) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .tx_valid     (tx_valid),
    .tx_abort     (tx_abort),
    .tx_ready     (tx_ready),
    .load_shifter (load_shifter),
    .shift_enable (shift_enable),
    .tx_sel       (tx_sel),
    .tx_busy      (tx_busy),
    .tx_done      (tx_done)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    num_checks++;
    if (got !== exp) begin
      num_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] obs();
    return {load_shifter, tx_sel, shift_enable, tx_done, tx_ready, tx_busy};
  endfunction

  // Expected outputs in cycle c of a frame accepted at cycle 0; ab is the
  // cycle carrying tx_abort (-1 for none)
  function automatic logic [6:0] frame_vec(input int c, input int ab);
    logic [1:0] sel;
    logic       sh;
    logic       dn;
    logic       ld;
    if (c == 0)                sel = 2'd0;
    else if (c <= C)           sel = 2'd1;
    else if (c <= (N + 1) * C) sel = 2'd2;
    else if (c <= FRAME)       sel = 2'd3;
    else                       sel = 2'd0;
    sh = (c >= 2 * C) && (c <= (N + 1) * C) && (c % C == 0) && (c != ab);
    dn = (c == FRAME) && (c != ab);
    ld = (c == 0);
    return {ld, sel, sh, dn, (sel == 2'd0), (sel != 2'd0)};
  endfunction

  // Apply inputs on the falling edge, let combinational outputs settle
  task automatic drive(input logic v, input logic a);
    @(negedge clk);
    tx_valid = v;
    tx_abort = a;
    #1;
  endtask

  // Run cycles 0..last of a frame, checking every cycle
  task automatic run_frame(input string name, input bit hold, input int ab, input int last);
    for (int c = 0; c <= last; c++) begin
      drive((c == 0) || hold, (c == ab));
      if (tx_done) done_seen++;
      check_val($sformatf("%s c=%0d", name, c), 32'(obs()), 32'(frame_vec(c, ab)));
    end
  endtask

  initial begin
    n_rst    = 1'b0;
    tx_valid = 1'b0;
    tx_abort = 1'b0;

    // Reset and idle
    repeat (2) @(negedge clk);
    #1;
    check_val("rst_hold", 32'(obs()), 32'(IDLE_VEC));
    @(negedge clk);
    n_rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0);
      check_val($sformatf("idle %0d", i), 32'(obs()), 32'(IDLE_VEC));
    end

    // Single byte, including the return to IDLE at cycle 101
    run_frame("single", 1'b0, -1, FRAME + 1);

    // tx_valid held high: accepts at 0 and 101 only
    done_seen = 0;
    run_frame("hold1", 1'b1, -1, FRAME);
    run_frame("hold2", 1'b1, -1, FRAME);
    check_val("hold_done_count", 32'(done_seen), 32'd2);
    drive(1'b0, 1'b0);
    check_val("hold_idle", 32'(obs()), 32'(IDLE_VEC));

    // Abort mid-DATA at 45, new accept at 46 runs a full frame
    run_frame("abort45", 1'b0, 45, 45);
    run_frame("post_abort", 1'b0, -1, FRAME + 1);

    // Abort coincident with a DATA period end suppresses shift_enable
    run_frame("abort_pe", 1'b0, 50, 50);
    drive(1'b0, 1'b0);
    check_val("abort_pe_idle", 32'(obs()), 32'(IDLE_VEC));

    // Abort on the STOP period end suppresses tx_done
    run_frame("abort_stop", 1'b0, FRAME, FRAME);
    drive(1'b0, 1'b0);
    check_val("abort_stop_idle", 32'(obs()), 32'(IDLE_VEC));

    // Abort and valid together in IDLE: no accept; accept once abort drops
    drive(1'b1, 1'b1);
    check_val("idle_abort", 32'(obs()), 32'(BLOCK_VEC));
    drive(1'b1, 1'b1);
    check_val("idle_abort_hold", 32'(obs()), 32'(BLOCK_VEC));
    run_frame("after_idle_abort", 1'b0, -1, FRAME + 1);

    // Asynchronous reset mid-STOP, then a fresh frame
    run_frame("pre_reset", 1'b0, -1, 95);
    #2;
    n_rst = 1'b0;
    #1;
    check_val("async_rst", 32'(obs()), 32'(IDLE_VEC));
    drive(1'b0, 1'b0);
    check_val("rst_held", 32'(obs()), 32'(IDLE_VEC));
    @(negedge clk);
    n_rst = 1'b1;
    run_frame("post_reset", 1'b0, -1, FRAME + 1);

    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

endmodule
`default_nettype wire
